// File: rtl/dmem_pkg.sv
// dmem_pkg: shared data-memory types and constants for the memory and its bus initiators
package dmem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, FIN = 2'd3} dmem_state_e;
  localparam int WORD_BYTES = 4;
  localparam int DATA_W = 32;
endpackage

// File: rtl/dmem_copy_engine.sv
// dmem_copy_engine: word block-copy initiator on the data-memory port, one read plus one write per word
module dmem_copy_engine import dmem_pkg::*; #(
  parameter int LEN_W = 9,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  words_done,
  input  logic              mem_gnt,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  dmem_state_e state, state_n;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic [LEN_W-1:0] rem;
  logic [DATA_W-1:0] data_q;
  logic err_q, mis;
  assign mis = |(src_addr[1:0] | dst_addr[1:0]);
  assign busy = state == READ || state == WRITE;
  assign done = state == FIN;
  assign err = done & err_q;
  // strobes depend only on state and grant so start/abort never reach the bus combinationally
  assign mem_rd = state == READ && mem_gnt;
  assign mem_wr = state == WRITE && mem_gnt;
  assign mem_addr = mem_rd ? src_ptr : mem_wr ? dst_ptr : '0;
  assign mem_wdata = data_q;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = !start ? IDLE : (mis || len == '0) ? FIN : READ;
      READ: state_n = abort ? FIN : mem_gnt ? WRITE : READ;
      WRITE: state_n = (abort || (mem_gnt && rem == LEN_W'(1))) ? FIN : mem_gnt ? READ : WRITE;
      FIN: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      src_ptr <= '0;
      dst_ptr <= '0;
      rem <= '0;
      data_q <= '0;
      words_done <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        src_ptr <= src_addr;
        dst_ptr <= dst_addr;
        rem <= len;
        words_done <= '0;
        err_q <= mis;
      end
      if (mem_rd) begin
        data_q <= mem_rdata;
        src_ptr <= src_ptr + ADDR_W'(WORD_BYTES);
      end
      if (mem_wr) begin
        dst_ptr <= dst_ptr + ADDR_W'(WORD_BYTES);
        words_done <= words_done + LEN_W'(1);
        rem <= rem - LEN_W'(1);
      end
      if (busy && abort) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dmem_copy_engine.sv
// tb_dmem_copy_engine: directed and randomized copies against a word-array reference of the 256-byte memory
module tb_dmem_copy_engine;
  logic clk = 0, reset = 1, start = 0, abort = 0, mem_gnt = 1;
  logic [31:0] src_addr = 0, dst_addr = 0;
  logic [8:0] len = 0;
  logic busy, done, err, mem_rd, mem_wr;
  logic [8:0] words_done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [64];
  logic [31:0] exp_mem [64];
  logic load_en = 0;
  logic [5:0] load_idx = 0;
  logic [31:0] load_val = 0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  dmem_copy_engine dut (.clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .abort(abort), .busy(busy), .done(done), .err(err), .words_done(words_done),
    .mem_gnt(mem_gnt), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata));
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk)
    if (load_en) mem[load_idx] <= load_val;
    else if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic preload(input int idx, input logic [31:0] v);
    load_en = 1; load_idx = 6'(idx); load_val = v; exp_mem[idx] = v;
    @(posedge clk); #1 load_en = 0;
  endtask
  // reference: count granted access cycles until 2n accesses or an abort, then copy word by word ascending
  task automatic model(input logic [31:0] s, d, input int n, input logic [63:0] low, input int ab,
                       output int dc, output logic e, output int k);
    k = 0; e = 0; dc = 1;
    if (s[1:0] != 0 || d[1:0] != 0) e = 1;
    else if (n > 0)
      for (int c = 1; c < 400; c++) begin
        if (k < 2 * n && (c >= 64 || !low[c])) k++;
        if (c == ab) begin dc = c + 1; e = 1; break; end
        if (k == 2 * n) begin dc = c + 1; break; end
      end
    for (int i = 0; i < k / 2; i++) exp_mem[((d >> 2) + i) % 64] = exp_mem[((s >> 2) + i) % 64];
  endtask
  task automatic run(input logic [31:0] s, d, input int n, input logic [63:0] low, input int ab, input int rs,
                     output int dc, output logic e, output int nrd, nwr, nbusy, bad);
    start = 1; src_addr = s; dst_addr = d; len = 9'(n); abort = 0; mem_gnt = 1;
    dc = -1; e = 0; nrd = 0; nwr = 0; nbusy = 0; bad = 0;
    for (int c = 1; c <= 300 && dc < 0; c++) begin
      @(posedge clk); #1;
      start = (c == rs);
      if (c == rs) begin src_addr = 32'h4; dst_addr = 32'h8; len = 9'd3; end
      mem_gnt = c < 64 ? !low[c] : 1'b1;
      abort = (c == ab);
      @(negedge clk);
      nrd += int'(mem_rd); nwr += int'(mem_wr); nbusy += int'(busy);
      if ((!mem_gnt && (mem_rd || mem_wr)) || (!mem_rd && !mem_wr && mem_addr != 0)) bad++;
      if (done) begin dc = c; e = err; end
    end
    @(posedge clk); #1 start = 0; abort = 0; mem_gnt = 1;
  endtask
  task automatic do_case(input string tag, input logic [31:0] s, d, input int n, input logic [63:0] low,
                         input int ab, input int rs);
    int edc, k, dc, nrd, nwr, nbusy, bad, mm;
    logic ee, e;
    model(s, d, n, low, ab, edc, ee, k);
    run(s, d, n, low, ab, rs, dc, e, nrd, nwr, nbusy, bad);
    mm = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== exp_mem[i]) mm++;
    chk({tag, ".done_cycle"}, 64'(dc), 64'(edc));
    chk({tag, ".err"}, 64'(e), 64'(ee));
    chk({tag, ".words_done"}, 64'(words_done), 64'(k / 2));
    chk({tag, ".reads"}, 64'(nrd), 64'((k + 1) / 2));
    chk({tag, ".writes"}, 64'(nwr), 64'(k / 2));
    chk({tag, ".busy_cycles"}, 64'(nbusy), 64'(k == 0 && !ee ? 0 : edc - 1));
    chk({tag, ".bus_rules"}, 64'(bad), 64'(0));
    chk({tag, ".mem_words_wrong"}, 64'(mm), 64'(0));
  endtask
  initial begin
    logic [63:0] low;
    int ws, wd, n;
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    for (int i = 0; i < 4; i++) preload(i, 32'(i + 1));
    chk("reset.strobes", {62'(0), mem_rd, mem_wr}, 64'(0));
    chk("reset.status", {61'(0), busy, done, err}, 64'(0));
    chk("reset.addr_wdata", {mem_addr, mem_wdata}, 64'(0));
    chk("reset.words_done", 64'(words_done), 64'(0));
    reset = 0;
    @(posedge clk); #1;
    do_case("t1_basic", 32'h0, 32'h40, 4, 64'(0), 0, 0);
    chk("t1.dst_word3", 64'(mem[19]), 64'(4));
    do_case("t2_len0", 32'h10, 32'h20, 0, 64'(0), 0, 0);
    do_case("t3_misaligned", 32'h2, 32'h60, 3, 64'(0), 0, 0);
    do_case("t4_stall", 32'h0, 32'h80, 4, 64'h78, 0, 0);
    do_case("t5_abort", 32'h20, 32'hA0, 8, 64'(0), 4, 0);
    do_case("wrap", 32'hFFFFFFF8, 32'h80, 3, 64'(0), 0, 0);
    do_case("overlap_fwd", 32'h40, 32'h44, 5, 64'(0), 0, 0);
    // reset lands in the third READ cycle (cycle 5) of a six-word copy
    start = 1; src_addr = 32'h0; dst_addr = 32'hC0; len = 9'd6; mem_gnt = 1;
    for (int c = 1; c <= 5; c++) begin @(posedge clk); #1 start = 0; end
    chk("t6.reading_before_reset", 64'(mem_rd), 64'(1));
    #2 reset = 1;
    #1;
    chk("t6.strobes_drop", {62'(0), mem_rd, mem_wr}, 64'(0));
    chk("t6.busy_drop", 64'(busy), 64'(0));
    chk("t6.words_done_cleared", 64'(words_done), 64'(0));
    for (int i = 0; i < 2; i++) exp_mem[48 + i] = exp_mem[i];
    @(posedge clk); #1 reset = 0;
    n = 0;
    for (int c = 0; c < 5; c++) begin @(negedge clk); n += int'(done); end
    chk("t6.no_done_after_reset", 64'(n), 64'(0));
    @(posedge clk); #1;
    do_case("t6_restart", 32'h10, 32'hE0, 5, 64'(0), 0, 3);
    for (int r = 0; r < 6; r++) begin
      ws = $urandom_range(0, 63); wd = $urandom_range(0, 63); n = $urandom_range(1, 12);
      low = {$urandom, $urandom} & {$urandom, $urandom} & ~64'h1;
      do_case($sformatf("rand%0d", r), 32'(ws * 4), 32'(wd * 4), n, low, (r == 5) ? 2 * n - 1 : 0, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
